param_program_sequencer: RTL and testbench
==========================================

// Module: param_program_sequencer
// PURPOSE
//  Parametrised program sequencer for the micro core family: produces the program-memory fetch address each cycle.
//  Supersedes the fixed 8-bit sequencer: PC width is generic and jump targets are full width.
//  Adds CALL/RET with a hardware return stack of configurable depth, a fetch-hold (stall) input and sticky stack-error flags.
//  Sits between instruction_decoder (jmp/call/ret strobes) and program_memory (clocked on ~clk, address = pm_addr).
// PARAMETERS
//  PC_W        8  width of pc, pm_addr, jmp_addr and stack entries
//  STACK_DEPTH 4  return-stack entries (>=1); SP_W = $clog2(STACK_DEPTH+1)
// PORTS
//  clk        in   1     system clock; all state updates on rising edge
//  reset      in   1     asynchronous, active-low reset
//  hold       in   1     1 = stall: refetch current pc, ignore all flow controls
//  jmp        in   1     unconditional jump to jmp_addr
//  jmp_nz     in   1     conditional jump to jmp_addr when dont_jmp==0
//  dont_jmp   in   1     zero flag from computational unit
//  call       in   1     push pc+1, jump to jmp_addr
//  ret        in   1     pop stack top into pm_addr
//  jmp_addr   in   PC_W  absolute target address
//  pm_addr    out  PC_W  next fetch address (combinational)
//  pc         out  PC_W  registered address of the instruction being fetched
//  sp         out  SP_W  stack occupancy, 0..STACK_DEPTH
//  stack_err  out  1     sticky: call on full or ret on empty; cleared only by reset
// BEHAVIOUR
//  - Reset (reset==0, async): pc=0, sp=0, stack_err=0, stack contents=0; pm_addr forced to 0 while reset is low.
//  - Every rising edge: pc <= pm_addr. Zero-cycle latency from strobe to pm_addr; target appears on pc one edge later.
//  - pm_addr selection, highest priority first:
//    1 hold            -> pc (no stack change, no error)
//    2 ret             -> stack[sp-1], sp-- ; if sp==0: pc+1, stack_err<=1, sp unchanged
//    3 call            -> jmp_addr, push pc+1, sp++ ; if sp==STACK_DEPTH: pc+1, stack_err<=1, no push
//    4 jmp             -> jmp_addr
//    5 jmp_nz & !dont_jmp -> jmp_addr
//    6 otherwise       -> pc+1
//  - Simultaneous strobes resolve strictly by the priority list; lower-priority strobes are dropped, not queued.
//  - pc+1 is modulo 2^PC_W: pc=all-ones wraps to 0. A pushed return address also wraps (call at all-ones pushes 0).
//  - Stack is LIFO; push and pop never occur in the same cycle (priority guarantees this).
//  - Occupancy reaching 0 or STACK_DEPTH is not an error. Only a rejected call/ret sets stack_err.
//  - Reset asserted mid-call/ret discards the stack (sp=0). Fetch restarts at 0 on the first edge after reset release.
//  - Stack storage is flops, not RAM, so ret data is available combinationally.
// CONFIGURATION
//  SEQ_DEBUG_EN defined:
//    - adds output from_PS [PC_W-1:0] = stack top (stack[sp-1]), or 0 when sp==0.
//    - adds output last_target [PC_W-1:0]: registers pm_addr on every taken jmp/jmp_nz/call/ret; reset 0.
//  SEQ_DEBUG_EN undefined:
//    - both ports and their logic are absent.
//    - all other behaviour is identical.
// TESTING (PC_W=8, STACK_DEPTH=4)
//  1 Reset low for 3 clk, release, no strobes -> pm_addr 0; pc sequence 0,1,2,3...; pc 8'hFF -> next pc 8'h00.
//  2 At pc=5: jmp_nz=1, jmp_addr=8'h40, dont_jmp=1 -> pc=6. Repeat with dont_jmp=0 -> pc=8'h40.
//  3 At pc=8'h10: call to 8'h80 -> pc=8'h80, sp=1. At 8'h85: ret -> pc=8'h11, sp=0.
//  4 Nested calls: 5 calls -> sp=4, 5th call gives pc+1 and stack_err=1. Then 4 rets restore addresses in LIFO order.
//    A 5th ret -> pc+1, sp stays 0, stack_err stays 1.
//  5 hold=1 together with jmp=1 for 2 cycles -> pc constant, jmp ignored. Same cycle call=1, ret=1 -> ret wins.
//  6 reset low asynchronously mid-cycle with sp=3 -> pc, sp and stack_err read 0 before the next clk edge.
//    With SEQ_DEBUG_EN, from_PS=0 and last_target=0.

Source files
------------

// File: rtl/param_program_sequencer.sv
// param_program_sequencer
//   Produces the program-memory fetch address every cycle for the micro core
//   family. Supports unconditional/conditional jumps, CALL/RET through a
//   flop-based return stack of STACK_DEPTH entries, a fetch hold and a sticky
//   stack-error flag.
//   Optional debug visibility is enabled by defining SEQ_DEBUG_EN
//   (adds from_PS and last_target outputs).
module param_program_sequencer #(
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 4,
  localparam int SP_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hold,
  input  logic            jmp,
  input  logic            jmp_nz,
  input  logic            dont_jmp,
  input  logic            call,
  input  logic            ret,
  input  logic [PC_W-1:0] jmp_addr,
  output logic [PC_W-1:0] pm_addr,
  output logic [PC_W-1:0] pc,
  output logic [SP_W-1:0] sp,
  output logic            stack_err
`ifdef SEQ_DEBUG_EN
  ,
  output logic [PC_W-1:0] from_PS,
  output logic [PC_W-1:0] last_target
`endif
);

  logic [PC_W-1:0] pc_r;
  logic [SP_W-1:0] sp_r;
  logic            err_r;
  logic [PC_W-1:0] stack_r [STACK_DEPTH];

  logic [PC_W-1:0] pc_inc_s;
  logic [PC_W-1:0] top_s;
  logic [PC_W-1:0] nxt_s;
  logic            empty_s;
  logic            full_s;
  logic            push_s;
  logic            pop_s;
  logic            err_set_s;

  assign pc_inc_s = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
  assign empty_s  = (sp_r == '0);
  assign full_s   = (sp_r == SP_W'(STACK_DEPTH));

  // Stack top read mux: entry sp-1, zero when the stack is empty.
  always_comb begin
    top_s = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (SP_W'(i + 1) == sp_r) begin
        top_s = stack_r[i];
      end else begin
        top_s = top_s;
      end
    end
  end

  // Next-address priority: hold > ret > call > jmp > jmp_nz > increment.
  always_comb begin
    nxt_s     = pc_inc_s;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    err_set_s = 1'b0;
    if (hold) begin
      nxt_s = pc_r;
    end else if (ret) begin
      if (empty_s) begin
        err_set_s = 1'b1;
      end else begin
        nxt_s = top_s;
        pop_s = 1'b1;
      end
    end else if (call) begin
      if (full_s) begin
        err_set_s = 1'b1;
      end else begin
        nxt_s  = jmp_addr;
        push_s = 1'b1;
      end
    end else if (jmp || (jmp_nz && !dont_jmp)) begin
      nxt_s = jmp_addr;
    end else begin
      nxt_s = pc_inc_s;
    end
  end

  // Fetch address is held at zero while reset is asserted.
  assign pm_addr   = reset ? nxt_s : '0;
  assign pc        = pc_r;
  assign sp        = sp_r;
  assign stack_err = err_r;

  // PC, stack pointer, sticky error and return-stack storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r  <= '0;
      sp_r  <= '0;
      err_r <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_r[i] <= '0;
      end
    end else begin
      pc_r <= nxt_s;
      if (push_s) begin
        sp_r <= sp_r + SP_W'(1);
      end else if (pop_s) begin
        sp_r <= sp_r - SP_W'(1);
      end else begin
        sp_r <= sp_r;
      end
      if (err_set_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (push_s && (SP_W'(i) == sp_r)) begin
          stack_r[i] <= pc_inc_s;
        end else begin
          stack_r[i] <= stack_r[i];
        end
      end
    end
  end

`ifdef SEQ_DEBUG_EN
  logic            taken_s;
  logic [PC_W-1:0] last_target_r;

  // A flow change is taken only when it actually redirects the fetch.
  always_comb begin
    taken_s = 1'b0;
    if (hold) begin
      taken_s = 1'b0;
    end else if (ret) begin
      taken_s = !empty_s;
    end else if (call) begin
      taken_s = !full_s;
    end else begin
      taken_s = jmp || (jmp_nz && !dont_jmp);
    end
  end

  // Capture the destination of every taken jump, call or return.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_target_r <= '0;
    end else if (taken_s) begin
      last_target_r <= nxt_s;
    end else begin
      last_target_r <= last_target_r;
    end
  end

  assign from_PS     = top_s;
  assign last_target = last_target_r;
`endif

endmodule

// File: tb/tb_param_program_sequencer.sv
// Self-checking bench for param_program_sequencer (PC_W=8, STACK_DEPTH=4).
// A behavioural model (pc value plus a queue used as the return stack) predicts
// every output; directed scenarios add literal expectations.
module tb_param_program_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       hold, jmp, jmp_nz, dont_jmp, call, ret;
  logic [7:0] jmp_addr;
  logic [7:0] pm_addr, pc;
  logic [2:0] sp;
  logic       stack_err;
`ifdef SEQ_DEBUG_EN
  logic [7:0] from_PS, last_target;
`endif

  int errors = 0;
  int checks = 0;

  // model state
  logic [7:0] m_pc;
  logic [7:0] m_stk[$];
  bit         m_err;
  logic [7:0] m_lt;

  param_program_sequencer #(.PC_W(8), .STACK_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .hold(hold), .jmp(jmp), .jmp_nz(jmp_nz),
    .dont_jmp(dont_jmp), .call(call), .ret(ret), .jmp_addr(jmp_addr),
    .pm_addr(pm_addr), .pc(pc), .sp(sp), .stack_err(stack_err)
`ifdef SEQ_DEBUG_EN
    , .from_PS(from_PS), .last_target(last_target)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 8'h00;
    m_stk.delete();
    m_err = 1'b0;
    m_lt = 8'h00;
  endtask

  // One clock cycle: drive inputs after the falling edge, compare all outputs
  // against the model, then advance the model across the rising edge.
  task automatic cycle(input bit h, input bit j, input bit jn, input bit dj,
                       input bit c, input bit r, input logic [7:0] a);
    logic [7:0] inc;
    logic [7:0] exp;
    bit push, pop, seterr, taken;
    push = 1'b0; pop = 1'b0; seterr = 1'b0; taken = 1'b0;
    hold = h; jmp = j; jmp_nz = jn; dont_jmp = dj; call = c; ret = r; jmp_addr = a;
    #1;
    inc = m_pc + 8'd1;
    if (h) exp = m_pc;
    else if (r) begin
      if (m_stk.size() == 0) begin exp = inc; seterr = 1'b1; end
      else begin exp = m_stk[$]; pop = 1'b1; taken = 1'b1; end
    end else if (c) begin
      if (m_stk.size() == 4) begin exp = inc; seterr = 1'b1; end
      else begin exp = a; push = 1'b1; taken = 1'b1; end
    end else if (j || (jn && !dj)) begin exp = a; taken = 1'b1; end
    else exp = inc;
    check("pm_addr", 32'(pm_addr), 32'(exp));
    check("pc", 32'(pc), 32'(m_pc));
    check("sp", 32'(sp), 32'(m_stk.size()));
    check("stack_err", 32'(stack_err), 32'(m_err));
`ifdef SEQ_DEBUG_EN
    check("from_PS", 32'(from_PS), (m_stk.size() == 0) ? 32'd0 : 32'(m_stk[$]));
    check("last_target", 32'(last_target), 32'(m_lt));
`endif
    @(posedge clk);
    m_pc = exp;
    if (push) m_stk.push_back(inc);
    if (pop) void'(m_stk.pop_back());
    if (seterr) m_err = 1'b1;
    if (taken) m_lt = exp;
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic do_jmp(input logic [7:0] a);
    cycle(0, 1, 0, 0, 0, 0, a);
  endtask

  task automatic do_call(input logic [7:0] a);
    cycle(0, 0, 0, 0, 1, 0, a);
  endtask

  task automatic do_ret();
    cycle(0, 0, 0, 0, 0, 1, 8'h00);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_reset();
    check("rst_pm_addr", 32'(pm_addr), 32'h0);
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_sp", 32'(sp), 32'h0);
    check("rst_err", 32'(stack_err), 32'h0);
    reset = 1'b1;
  endtask

  initial begin
    hold = 1'b0; jmp = 1'b0; jmp_nz = 1'b0; dont_jmp = 1'b0;
    call = 1'b0; ret = 1'b0; jmp_addr = 8'h00;
    model_reset();
    apply_reset();

    // 1: free-running fetch and wrap
    check("t1_pc0", 32'(pc), 32'h00);
    idle(); check("t1_pc1", 32'(pc), 32'h01);
    idle(); check("t1_pc2", 32'(pc), 32'h02);
    idle(); check("t1_pc3", 32'(pc), 32'h03);
    do_jmp(8'hFF); check("t1_pcff", 32'(pc), 32'hFF);
    idle(); check("t1_wrap", 32'(pc), 32'h00);
    do_jmp(8'hFF);
    do_call(8'h10); check("t1_callwrap_sp", 32'(sp), 32'd1);
    do_ret(); check("t1_retwrap_pc", 32'(pc), 32'h00);

    // 2: conditional jump
    do_jmp(8'h05);
    cycle(0, 0, 1, 1, 0, 0, 8'h40); check("t2_nottaken", 32'(pc), 32'h06);
    do_jmp(8'h05);
    cycle(0, 0, 1, 0, 0, 0, 8'h40); check("t2_taken", 32'(pc), 32'h40);

    // 3: call / ret
    do_jmp(8'h10);
    do_call(8'h80); check("t3_call_pc", 32'(pc), 32'h80); check("t3_call_sp", 32'(sp), 32'd1);
    do_jmp(8'h85);
    do_ret(); check("t3_ret_pc", 32'(pc), 32'h11); check("t3_ret_sp", 32'(sp), 32'd0);

    // 4: nesting, overflow and underflow
    do_jmp(8'h01);
    do_call(8'h20); do_call(8'h30); do_call(8'h40); do_call(8'h50);
    check("t4_full_sp", 32'(sp), 32'd4); check("t4_noerr", 32'(stack_err), 32'd0);
    do_call(8'h60); check("t4_ovf_pc", 32'(pc), 32'h51); check("t4_ovf_err", 32'(stack_err), 32'd1);
    do_ret(); check("t4_r1", 32'(pc), 32'h41);
    do_ret(); check("t4_r2", 32'(pc), 32'h31);
    do_ret(); check("t4_r3", 32'(pc), 32'h21);
    do_ret(); check("t4_r4", 32'(pc), 32'h02);
    do_ret(); check("t4_unf_pc", 32'(pc), 32'h03);
    check("t4_unf_sp", 32'(sp), 32'd0); check("t4_unf_err", 32'(stack_err), 32'd1);

    // 5: hold dominates, ret beats call
    cycle(1, 1, 0, 0, 0, 0, 8'hAA); check("t5_hold1", 32'(pc), 32'h03);
    cycle(1, 1, 0, 0, 0, 0, 8'hAA); check("t5_hold2", 32'(pc), 32'h03);
    do_call(8'h70);
    cycle(0, 0, 0, 0, 1, 1, 8'h90); check("t5_retwins_pc", 32'(pc), 32'h04);
    check("t5_retwins_sp", 32'(sp), 32'd0);

    // randomized traffic
    apply_reset();
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
            1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
            8'($urandom_range(0, 255)));
      if (n == 1500) apply_reset();
    end

    // 6: asynchronous reset mid-cycle
    apply_reset();
    do_call(8'h11); do_call(8'h22); do_call(8'h33);
    check("t6_sp3", 32'(sp), 32'd3);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("t6_pc", 32'(pc), 32'h0);
    check("t6_sp", 32'(sp), 32'h0);
    check("t6_err", 32'(stack_err), 32'h0);
    check("t6_pm", 32'(pm_addr), 32'h0);
`ifdef SEQ_DEBUG_EN
    check("t6_from_PS", 32'(from_PS), 32'h0);
    check("t6_last_target", 32'(last_target), 32'h0);
`endif
    @(negedge clk);
    model_reset();
    reset = 1'b1;
    idle(); idle();
    check("t6_restart", 32'(pc), 32'h02);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
